// File: rtl/eq_pkg.sv
// Shared definitions for the band-filter MAC sequencers: FSM state encoding
// and the default tap count / pipeline latency used by every band.
package eq_pkg;

  localparam int DEF_NUM_TAPS = 1021;
  localparam int DEF_PIPE_LAT = 2;
  localparam int DEF_ADDR_W   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // Increment that sticks once the ceiling is reached.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] ceil);
    return (val >= ceil) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-latency shift register used to align control strobes with the
// multiply-accumulate datapath. DEPTH must be at least 1.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift stages; the final stage is the registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Coefficient address and accumulator control sequencer for one FIR band.
// Tracks each sequencing run, aligns MAC controls to the pipeline, flags bad runs.
module fir_mac_sequencer
  import eq_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sequencing,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_vld,
  output logic              busy,
  output logic              ovr_err,
  output logic              short_err
);

  localparam int CNT_W = $clog2(NUM_TAPS + 1);
  localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  seq_state_t        state_r;
  seq_state_t        state_nxt_s;
  logic [DRN_W-1:0]  drain_cnt_r;
  logic [DRN_W-1:0]  drain_cnt_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic [CNT_W-1:0]  taps_r;
  logic [CNT_W-1:0]  taps_nxt_s;
  logic              qual_prev_r;
  logic              ovr_err_r;
  logic              short_err_r;

  logic              qual_s;
  logic              first_tap_s;
  logic              fall_s;
  logic              ovr_evt_s;
  logic              short_evt_s;
  logic [2:0]        ctl_in_s;
  logic [2:0]        ctl_out_s;

  // Run qualification and error event decode.
  always_comb begin
    qual_s      = sequencing && (taps_r < CNT_W'(NUM_TAPS));
    first_tap_s = sequencing && (state_r != RUN);
    fall_s      = qual_prev_r && !qual_s;
    ovr_evt_s   = sequencing && (taps_r == CNT_W'(NUM_TAPS));
    short_evt_s = (state_r == RUN) && !sequencing && (taps_r < CNT_W'(NUM_TAPS));
  end

  // Next-state and drain counter.
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    case (state_r)
      IDLE: begin
        drain_cnt_nxt_s = {DRN_W{1'b0}};
        if (sequencing) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        drain_cnt_nxt_s = {DRN_W{1'b0}};
        if (sequencing) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DRAIN: begin
        // A new run may start before the previous one has drained.
        if (sequencing) begin
          state_nxt_s     = RUN;
          drain_cnt_nxt_s = {DRN_W{1'b0}};
        end else if (drain_cnt_r == DRN_W'(PIPE_LAT - 1)) begin
          state_nxt_s     = IDLE;
          drain_cnt_nxt_s = {DRN_W{1'b0}};
        end else begin
          state_nxt_s     = DRAIN;
          drain_cnt_nxt_s = drain_cnt_r + {{(DRN_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        drain_cnt_nxt_s = {DRN_W{1'b0}};
      end
    endcase
  end

  // Address and tap counter: advance while sequencing, otherwise park at zero.
  always_comb begin
    addr_nxt_s = addr_r;
    taps_nxt_s = taps_r;
    if (sequencing) begin
      addr_nxt_s = ADDR_W'(sat_inc(32'(addr_r), 32'(NUM_TAPS - 1)));
      taps_nxt_s = CNT_W'(sat_inc(32'(taps_r), 32'(NUM_TAPS)));
    end else begin
      addr_nxt_s = {ADDR_W{1'b0}};
      taps_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      drain_cnt_r <= {DRN_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      taps_r      <= {CNT_W{1'b0}};
      qual_prev_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      addr_r      <= addr_nxt_s;
      taps_r      <= taps_nxt_s;
      qual_prev_r <= qual_s;
    end
  end

  // Sticky error flags; a fresh event beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_err_r   <= 1'b0;
      short_err_r <= 1'b0;
    end else begin
      ovr_err_r   <= ovr_evt_s   | (ovr_err_r   & ~err_clr);
      short_err_r <= short_evt_s | (short_err_r & ~err_clr);
    end
  end

  assign ctl_in_s = {first_tap_s, qual_s, fall_s};

  pipe_delay #(
    .WIDTH (3),
    .DEPTH (PIPE_LAT)
  ) u_ctl_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (ctl_in_s),
    .dout (ctl_out_s)
  );

  assign acc_clr    = ctl_out_s[2];
  assign acc_en     = ctl_out_s[1];
  assign out_vld    = ctl_out_s[0];
  assign coeff_addr = addr_r;
  assign busy       = (state_r != IDLE);
  assign ovr_err    = ovr_err_r;
  assign short_err  = short_err_r;

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Control block for one FIR band filter. It watches the `sequencing` strobe from a band queue and generates the coefficient ROM address. It also generates the accumulator clear/enable controls aligned to the datapath pipeline, and a one-cycle `out_vld` when a filtered sample is complete. It sits between the high/low frequency queues and the shared multiply-accumulate datapath. It also flags malformed sequencing runs.

Parameters:
- `NUM_TAPS`, default 1021: coefficients per run; the expected `sequencing` high length in cycles.
- `ADDR_W`, default 10: coefficient ROM address width; must satisfy 2^ADDR_W >= NUM_TAPS.
- `PIPE_LAT`, default 2: cycles from the address/sample presented to the product valid at the accumulator input (ROM read plus multiplier register).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `sequencing`  in  1  from queue; high one cycle per tap while samples are being read out
- `err_clr`  in  1  synchronous clear of sticky error flags
- `coeff_addr`  out  ADDR_W  coefficient ROM address
- `acc_clr`  out  1  accumulator loads product instead of adding (first tap)
- `acc_en`  out  1  accumulator captures/adds product this cycle
- `out_vld`  out  1  one-cycle pulse; accumulator holds the finished result
- `busy`  out  1  high in RUN or DRAIN
- `ovr_err`  out  1  sticky; run exceeded NUM_TAPS
- `short_err`  out  1  sticky; run ended before NUM_TAPS

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE; `coeff_addr`=0; tap counter=0; delay lines cleared.
  - All outputs 0.
  - Reset asserted mid-run abandons the run with no `out_vld`.
- All outputs are registered except `busy`, which is decoded from state.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - `coeff_addr` held 0.
  - `sequencing`=1 at cycle t → RUN. Address 0 is valid at t, and `coeff_addr`=1 at t+1.
- RUN:
  - Each cycle `sequencing`=1: tap counter++ and `coeff_addr`++.
  - Address saturates at NUM_TAPS-1.
  - `sequencing`=0 → DRAIN.
- Overrun: if the tap counter reaches NUM_TAPS while `sequencing` is still 1:
  - set `ovr_err`;
  - excess cycles produce no `acc_en`;
  - the address stays saturated.
- DRAIN:
  - Counts PIPE_LAT cycles, then → IDLE with `coeff_addr`=0.
  - Short run: if the run length < NUM_TAPS, set `short_err`. `out_vld` is still produced.
- Pipeline alignment:
  - `acc_en` = (`sequencing` AND taps<NUM_TAPS) delayed exactly PIPE_LAT cycles.
  - `acc_clr` = first-tap-of-run flag delayed PIPE_LAT cycles; it coincides with the first `acc_en` of each run.
  - `out_vld` = falling edge of qualified `sequencing`, delayed PIPE_LAT cycles. It fires the cycle after the last `acc_en`.
- Back-to-back runs:
  - `sequencing` rising while in DRAIN → RUN immediately, address and counter restart at 0.
  - The previous run's `out_vld` still fires on schedule from the delay line.
  - The new run's `acc_clr` follows per the alignment rule.
- Single-cycle run (one high cycle):
  - `acc_clr` and `acc_en` in the same cycle; `out_vld` the next cycle.
  - Sets `short_err` if NUM_TAPS>1.
- Error flags:
  - Sticky until `err_clr` or `rst`.
  - A new error event in the same cycle as `err_clr` wins (flag ends set).

Decomposition:
- Shared package `eq_pkg`:
  - FSM state enum `seq_state_t` {IDLE, RUN, DRAIN};
  - the `NUM_TAPS`/`PIPE_LAT` defaults used by all bands.
- One natural sub-module: `pipe_delay` (parameterized width × PIPE_LAT shift register, async active-high reset). It is instantiated for the `acc_en`/`acc_clr`/`out_vld` delay lines.

Test Plan:
1. NUM_TAPS=4, PIPE_LAT=2; `sequencing` high 4 cycles from t=10:
   - `coeff_addr` 0,1,2,3;
   - `acc_clr`@12;
   - `acc_en`@12–15;
   - `out_vld`@16 only;
   - no errors; `busy` low from 17.
2. Same parameters, `sequencing` high 6 cycles:
   - `acc_en` exactly 4 cycles;
   - `coeff_addr` stuck at 3;
   - `ovr_err`=1 persists until `err_clr` pulse, then 0.
3. `sequencing` high 2 cycles:
   - `acc_en` 2 cycles;
   - `out_vld` once;
   - `short_err`=1.
4. Run of 4, `sequencing` low 1 cycle, run of 4:
   - two `out_vld` pulses 5 cycles apart;
   - second `acc_clr` coincides with first `acc_en` of run 2;
   - `coeff_addr` restarts at 0.
5. `rst` asserted asynchronously at mid-run tap 2:
   - all outputs 0 immediately;
   - no `out_vld`;
   - after release, a fresh 4-tap run behaves as scenario 1.
6. Defaults (1021, 2) with the RN52/I2S/queue chain:
   - one `out_vld` per queue write;
   - 1021 `acc_en` per run;
   - zero error flags over 3M cycles.
